// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job path: sequencer states, error codes and job size.
package rsa_pkg;

  localparam int unsigned FIFO_CNT_W = 5;
  localparam logic [FIFO_CNT_W-1:0] JOB_BYTES = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_EXEC,
    ST_SEND,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_LOAD_TMO = 2'b01,
    ERR_BAD_MOD  = 2'b10,
    ERR_EXEC_TMO = 2'b11
  } err_code_t;

  // Byte idx of a little-endian word; idx 0 is the LSB.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/rsa_job_sequencer_if.sv
// Bundle of the sequencer's loader, engine, transmit and status signals.
interface rsa_job_sequencer_if;
  import rsa_pkg::*;

  logic                  enable;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  load_req;
  logic                  load_done;
  logic [31:0]           key;
  logic [31:0]           mod;
  logic [31:0]           exp_key;
  logic [31:0]           exp_mod;
  logic                  exp_start;
  logic                  exp_done;
  logic [31:0]           exp_result;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  err;
  logic [1:0]            err_code;
  logic                  clr_err;
  logic [15:0]           job_count;
  // Maintenance preset of the completed-job counter.
  logic                  cnt_load;
  logic [15:0]           cnt_val;

  modport master (
    input  enable, fifo_count, load_done, key, mod, exp_done, exp_result,
           tx_ready, clr_err, cnt_load, cnt_val,
    output load_req, exp_key, exp_mod, exp_start, tx_data, tx_valid,
           busy, err, err_code, job_count
  );

  modport slave (
    output enable, fifo_count, load_done, key, mod, exp_done, exp_result,
           tx_ready, clr_err, cnt_load, cnt_val,
    input  load_req, exp_key, exp_mod, exp_start, tx_data, tx_valid,
           busy, err, err_code, job_count
  );

endinterface

// File: rtl/rsa_tx_serializer.sv
// Streams a 32-bit word as 4 bytes, LSB first, over valid/ready; done pulses on the last handshake.
module rsa_tx_serializer
  import rsa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] data_q;
  logic [1:0]  idx_q;
  logic        valid_q;
  logic        fire;

  assign fire = valid_q && tx_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) valid_q <= 1'b0;
    end
  end

  // Byte only moves on a handshake, so tx_data holds steady under backpressure.
  assign tx_data_o  = byte_sel(data_q, idx_q);
  assign tx_valid_o = valid_q;
  assign done_o     = fire && (idx_q == 2'd3);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Job controller for the RFID RSA path: launches the loader, validates operands,
// runs the exponentiation engine under watchdogs and streams the result out.
module rsa_job_sequencer
  import rsa_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned LOAD_TMO  = 64,
  parameter int unsigned EXEC_TMO  = 40000
) (
  input logic                 clk,
  input logic                 rst,
  rsa_job_sequencer_if.master bus
);

  localparam logic [TIMEOUT_W-1:0] LOAD_LIMIT = TIMEOUT_W'(LOAD_TMO);
  localparam logic [TIMEOUT_W-1:0] EXEC_LIMIT = TIMEOUT_W'(EXEC_TMO);

  state_t               state_q;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [31:0]          key_q, mod_q;
  logic                 load_req_q, exp_start_q;
  logic                 err_q;
  err_code_t            err_code_q, err_pend_q;
  logic [15:0]          job_count_q;
  logic                 ser_load, ser_done;

  // Saturating increment: a stuck watchdog parks at all-ones instead of wrapping.
  assign wdog_d   = (&wdog_q) ? wdog_q : wdog_q + TIMEOUT_W'(1);
  assign ser_load = (state_q == ST_EXEC) && bus.exp_done;

  // NOTE: every register here uses non-blocking assignment, so all branches
  // read pre-edge values and later assignments in the block take priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wdog_q      <= '0;
      key_q       <= '0;
      mod_q       <= '0;
      load_req_q  <= 1'b0;
      exp_start_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_pend_q  <= ERR_NONE;
      job_count_q <= '0;
    end else begin
      load_req_q  <= 1'b0;
      exp_start_q <= 1'b0;
      if (bus.clr_err) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      if (bus.cnt_load) job_count_q <= bus.cnt_val;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.enable && (bus.fifo_count >= JOB_BYTES)) begin
            load_req_q <= 1'b1;
            wdog_q     <= '0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.load_done) begin
            key_q   <= bus.key;
            mod_q   <= bus.mod;
            wdog_q  <= '0;
            state_q <= ST_CHECK;
          end else if (wdog_q == LOAD_LIMIT) begin
            err_pend_q <= ERR_LOAD_TMO;
            wdog_q     <= '0;
            state_q    <= ST_ERROR;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ST_CHECK: begin
          wdog_q <= '0;
          if (mod_q < 32'd2) begin
            err_pend_q <= ERR_BAD_MOD;
            state_q    <= ST_ERROR;
          end else begin
            exp_start_q <= 1'b1;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // A completion landing on the timeout cycle is still accepted.
          if (bus.exp_done) begin
            wdog_q  <= '0;
            state_q <= ST_SEND;
          end else if (wdog_q == EXEC_LIMIT) begin
            err_pend_q <= ERR_EXEC_TMO;
            wdog_q     <= '0;
            state_q    <= ST_ERROR;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ST_SEND: begin
          if (ser_done) begin
            job_count_q <= job_count_q + 16'd1;
            wdog_q      <= '0;
            state_q     <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          // Placed after the clr_err handling so a fresh error beats a clear.
          err_q      <= 1'b1;
          err_code_q <= err_pend_q;
          wdog_q     <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rsa_tx_serializer u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .data_i     (bus.exp_result),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .tx_ready_i (bus.tx_ready),
    .done_o     (ser_done)
  );

  assign bus.load_req  = load_req_q;
  assign bus.exp_start = exp_start_q;
  assign bus.exp_key   = key_q;
  assign bus.exp_mod   = mod_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.job_count = job_count_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed bench for rsa_job_sequencer: scripted loader/engine, byte scoreboard on the tx port.
module tb_rsa_job_sequencer;
  import rsa_pkg::*;

  localparam int LOAD_TMO = 64;
  localparam int EXEC_TMO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsa_job_sequencer_if bus ();

  rsa_job_sequencer #(
    .TIMEOUT_W (16),
    .LOAD_TMO  (LOAD_TMO),
    .EXEC_TMO  (EXEC_TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_lreq  = 0;
  int         n_estart = 0;
  logic [7:0] sb[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return bus.load_req;
      1:       return bus.exp_start;
      2:       return bus.err;
      3:       return !bus.tx_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max, input string tag, output int n);
    n = 0;
    while (!probe(sel) && n < max) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(probe(sel)), 32'd1);
  endtask

  task automatic pulse_load_done(input logic [31:0] k, input logic [31:0] m);
    bus.key       = k;
    bus.mod       = m;
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
  endtask

  task automatic pulse_exp_done(input logic [31:0] r, input bit expect_out);
    if (expect_out)
      for (int i = 0; i < 4; i++) sb.push_back(r[8*i +: 8]);
    bus.exp_result = r;
    bus.exp_done   = 1'b1;
    tick();
    bus.exp_done   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    wait_for(3, 40, tag, n);
  endtask

  // Pulse counters and tx scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (bus.load_req)  n_lreq++;
      if (bus.exp_start) n_estart++;
      if (stall_q && bus.tx_valid) check("tx_stable", bus.tx_data, stall_data);
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb.size() == 0) check("tx_unexpected_byte", 32'(sb.size()), 32'd1);
        else check("tx_byte", bus.tx_data, sb.pop_front());
      end
      stall_q    = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          lreq0, est0;
    logic [15:0] jc0;

    bus.enable = 0; bus.fifo_count = '0; bus.load_done = 0; bus.key = '0; bus.mod = '0;
    bus.exp_done = 0; bus.exp_result = '0; bus.tx_ready = 0; bus.clr_err = 0;
    bus.cnt_load = 0; bus.cnt_val = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_load_req", bus.load_req, 0);
    check("rst_exp_start", bus.exp_start, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_job_count", bus.job_count, 0);
    rst = 1'b0;
    tick();

    // Normal job: 4^3 mod 33 = 31
    bus.tx_ready = 1; bus.enable = 1; bus.fifo_count = 5'd12;
    wait_for(0, 5, "job1_load_req", n);
    bus.fifo_count = 5'd0;
    repeat (10) tick();
    pulse_load_done(32'd3, 32'd33);
    check("job1_check_no_start", bus.exp_start, 0);
    tick();
    check("job1_exp_start_lat2", bus.exp_start, 1);
    check("job1_exp_key", bus.exp_key, 32'd3);
    check("job1_exp_mod", bus.exp_mod, 32'd33);
    repeat (20) tick();
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    repeat (79) tick();
    pulse_exp_done(32'd31, 1'b1);
    check("job1_tx_valid_lat1", bus.tx_valid, 1);
    check("job1_byte0", bus.tx_data, 32'h1F);
    n = 0;
    while (bus.tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("job1_send_cycles", n, 4);
    check("job1_job_count", bus.job_count, 1);
    check("job1_busy", bus.busy, 0);
    check("job1_err", bus.err, 0);
    check("job1_load_reqs", n_lreq, 1);
    check("job1_exp_starts", n_estart, 1);
    check("job1_sb_empty", 32'(sb.size()), 0);

    // Threshold: 11 bytes never launch, 12 launch on the next cycle
    bus.fifo_count = 5'd11;
    lreq0 = n_lreq;
    repeat (50) tick();
    check("thr_no_load_req", n_lreq - lreq0, 0);
    check("thr_idle", bus.busy, 0);
    bus.fifo_count = 5'd12;
    tick();
    check("thr_load_req_next", bus.load_req, 1);

    // Bad modulus on that job
    bus.fifo_count = 5'd0;
    repeat (3) tick();
    est0 = n_estart;
    pulse_load_done(32'd5, 32'd1);
    tick();
    tick();
    check("badmod_err", bus.err, 1);
    check("badmod_err_code", bus.err_code, 32'(ERR_BAD_MOD));
    check("badmod_idle", bus.busy, 0);
    check("badmod_no_start", n_estart - est0, 0);
    bus.clr_err = 1;
    tick();
    bus.clr_err = 0;
    check("clr_err_err", bus.err, 0);
    check("clr_err_code", bus.err_code, 0);

    // Load timeout: LOAD_TMO counted cycles, +1 to ERROR, +1 until err shows
    bus.fifo_count = 5'd12;
    wait_for(0, 5, "ltmo_load_req", n);
    bus.fifo_count = 5'd0;
    wait_for(2, LOAD_TMO + 20, "ltmo_err", n);
    check("ltmo_latency", n, LOAD_TMO + 2);
    check("ltmo_err_code", bus.err_code, 32'(ERR_LOAD_TMO));
    bus.clr_err = 1;
    tick();
    bus.clr_err = 0;

    // Exec timeout
    bus.fifo_count = 5'd12;
    wait_for(0, 5, "etmo_load_req", n);
    bus.fifo_count = 5'd0;
    pulse_load_done(32'd7, 32'd33);
    wait_for(1, 5, "etmo_exp_start", n);
    wait_for(2, EXEC_TMO + 20, "etmo_err", n);
    check("etmo_latency", n, EXEC_TMO + 2);
    check("etmo_err_code", bus.err_code, 32'(ERR_EXEC_TMO));
    bus.clr_err = 1;
    tick();
    bus.clr_err = 0;

    // exp_done on the timeout cycle wins
    bus.fifo_count = 5'd12;
    wait_for(0, 5, "tie_load_req", n);
    bus.fifo_count = 5'd0;
    pulse_load_done(32'd3, 32'd33);
    wait_for(1, 5, "tie_exp_start", n);
    repeat (EXEC_TMO) tick();
    pulse_exp_done(32'h0000_1234, 1'b1);
    check("tie_tx_valid", bus.tx_valid, 1);
    drain("tie_drain");
    check("tie_no_err", bus.err, 0);
    check("tie_job_count", bus.job_count, 2);

    // Backpressure 1,0,0,1 and enable dropped during EXEC
    jc0 = bus.job_count;
    bus.fifo_count = 5'd12;
    wait_for(0, 5, "bp_load_req", n);
    pulse_load_done(32'h11, 32'h1000_0001);
    wait_for(1, 5, "bp_exp_start", n);
    bus.enable = 0;
    repeat (30) tick();
    pulse_exp_done(32'hA1B2_C3D4, 1'b1);
    check("bp_byte0", bus.tx_data, 32'hD4);
    n = 0;
    while (bus.tx_valid && n < 40) begin
      bus.tx_ready = pat[n % 4];
      tick();
      n++;
    end
    check("bp_cycles", n, 8);
    bus.tx_ready = 1;
    lreq0 = n_lreq;
    repeat (20) tick();
    check("en_off_no_new_job", n_lreq - lreq0, 0);
    check("en_off_idle", bus.busy, 0);
    check("en_off_job_count", bus.job_count, 32'(jc0 + 16'd1));

    // Stray exp_done in IDLE is ignored
    pulse_exp_done(32'hDEAD, 1'b0);
    check("stray_exp_done_valid", bus.tx_valid, 0);
    check("stray_exp_done_busy", bus.busy, 0);

    // Reset while byte 2 is on the port
    bus.enable = 1;
    wait_for(0, 5, "rstmid_load_req", n);
    bus.fifo_count = 5'd0;
    pulse_load_done(32'd3, 32'd33);
    wait_for(1, 5, "rstmid_exp_start", n);
    repeat (5) tick();
    pulse_exp_done(32'h4433_2211, 1'b1);
    tick();
    tick();
    check("rstmid_byte2", bus.tx_data, 32'h33);
    rst = 1'b1;
    #1;
    check("rstmid_tx_valid", bus.tx_valid, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_job_count", bus.job_count, 0);
    sb.delete();
    lreq0 = n_lreq;
    est0  = n_estart;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rstmid_no_load_req", n_lreq - lreq0, 0);
    check("rstmid_no_exp_start", n_estart - est0, 0);

    // job_count wraps 0xFFFF -> 0
    bus.cnt_val  = 16'hFFFF;
    bus.cnt_load = 1;
    tick();
    bus.cnt_load = 0;
    check("wrap_preset", bus.job_count, 32'hFFFF);
    bus.fifo_count = 5'd12;
    wait_for(0, 5, "wrap_load_req", n);
    bus.fifo_count = 5'd0;
    pulse_load_done(32'd3, 32'd33);
    wait_for(1, 5, "wrap_exp_start", n);
    repeat (10) tick();
    pulse_exp_done(32'd5, 1'b1);
    drain("wrap_drain");
    tick();
    check("wrap_job_count", bus.job_count, 0);
    check("wrap_sb_empty", 32'(sb.size()), 0);
    check("wrap_err", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
